// File: rtl/sram_ext_dma.sv
// Burst DMA engine for the SRAM wrapper external port: word-burst writes from a stream,
// word-burst reads to a stream via a 2-entry buffer. Optional macro: SRAM_DMA_RANGE_CHECK_EN.
module sram_ext_dma #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BYTE_OFF = 2,
  parameter int unsigned LEN_W    = 9
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [63:0]       i_cmd_base,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [63:0]       o_mem_addr_ext,
  output logic              o_mem_wen_ext,
  output logic              o_mem_ren_ext,
  output logic [DATA_W-1:0] o_mem_wdata_ext,
  input  logic [DATA_W-1:0] i_mem_rdata_ext
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [63:0]       r_addr, w_addr_d, w_addr_inc;
  logic [LEN_W-1:0]  r_issue_left, w_issue_left_d;
  logic [LEN_W-1:0]  r_pop_left, w_pop_left_d;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr, r_rptr, r_inflight;
  logic [1:0]        r_count;
  logic [2:0]        w_occ;
  logic              w_issue, w_pop, w_reject;
  logic              w_unused_base;

  assign w_unused_base = ^i_cmd_base[BYTE_OFF-1:0];

  // Only the word-index field advances; bits above it stay fixed so the burst wraps in place.
  always_comb begin
    w_addr_inc = r_addr;
    w_addr_inc[ADDR_W+BYTE_OFF-1:BYTE_OFF] = r_addr[ADDR_W+BYTE_OFF-1:BYTE_OFF] + ADDR_W'(1);
  end

`ifdef SRAM_DMA_RANGE_CHECK_EN
  localparam int unsigned SumW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic [SumW-1:0] w_end;
  logic            r_err;
  assign w_end    = SumW'(i_cmd_base[ADDR_W+BYTE_OFF-1:BYTE_OFF]) + SumW'(i_cmd_len);
  assign w_reject = (r_state == StIdle) && i_cmd_valid && (w_end > (SumW'(1) << ADDR_W));
  assign o_err    = r_err;
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_err <= 1'b0;
    else           r_err <= w_reject;
  end
`else
  assign w_reject = 1'b0;
  assign o_err    = 1'b0;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_addr_d       = r_addr;
    w_issue_left_d = r_issue_left;
    w_pop_left_d   = r_pop_left;
    w_issue        = 1'b0;
    w_pop          = 1'b0;
    w_occ          = 3'(r_count) + 3'(r_inflight);
    o_cmd_ready    = 1'b0;
    o_wr_ready     = 1'b0;
    o_rd_valid     = 1'b0;
    o_mem_wen_ext  = 1'b0;
    o_mem_ren_ext  = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid && !w_reject) begin
          w_addr_d       = {i_cmd_base[63:BYTE_OFF], {BYTE_OFF{1'b0}}};
          w_issue_left_d = i_cmd_len;
          w_pop_left_d   = i_cmd_len;
          if (i_cmd_len == '0) w_state_d = StDone;
          else                 w_state_d = i_cmd_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        o_busy     = 1'b1;
        o_wr_ready = 1'b1;
        if (i_wr_valid) begin
          o_mem_wen_ext  = 1'b1;
          w_addr_d       = w_addr_inc;
          w_issue_left_d = r_issue_left - LEN_W'(1);
          if (r_issue_left == LEN_W'(1)) w_state_d = StDone;
        end
      end
      StRead: begin
        o_busy     = 1'b1;
        o_rd_valid = (r_count != 2'd0);
        w_pop      = o_rd_valid && i_rd_ready;
        // A pop this cycle frees a slot, which keeps back-to-back reads at one word per cycle.
        w_occ      = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        if (w_pop) begin
          w_pop_left_d = r_pop_left - LEN_W'(1);
          if (r_pop_left == LEN_W'(1)) w_state_d = StDone;
        end
        if ((r_issue_left != '0) && (w_occ < 3'd2)) begin
          w_issue        = 1'b1;
          o_mem_ren_ext  = 1'b1;
          w_addr_d       = w_addr_inc;
          w_issue_left_d = r_issue_left - LEN_W'(1);
        end
      end
      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_mem_addr_ext  = r_addr;
  assign o_mem_wdata_ext = o_mem_wen_ext ? i_wr_data : '0;
  assign o_rd_data       = r_fifo[r_rptr];
  assign o_rd_last       = o_rd_valid && (r_pop_left == LEN_W'(1));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_issue_left <= w_issue_left_d;
      r_pop_left   <= w_pop_left_d;
    end
  end

  // Read data arrives the cycle after the request and is captured at the end of that cycle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_fifo[r_wptr] <= i_mem_rdata_ext;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;
    end
  end

endmodule

// File: tb/tb_sram_ext_dma.sv
// Randomised self-checking bench for sram_ext_dma against a word-array reference memory.
module tb_sram_ext_dma;
  localparam int LW = 9;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_base;
  logic [8:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [63:0] mem_addr;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_ext_dma dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_base(cmd_base), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_mem_addr_ext(mem_addr), .o_mem_wen_ext(mem_wen), .o_mem_ren_ext(mem_ren),
    .o_mem_wdata_ext(mem_wdata), .i_mem_rdata_ext(mem_rdata)
  );

  // SRAM environment: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[9:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [63:0] base, input int i);
    return (int'(base[9:2]) + i) % 256;
  endfunction

  function automatic logic [63:0] exp_addr(input logic [63:0] base, input int i);
    logic [63:0] a;
    a[63:10] = base[63:10];
    a[9:0]   = 10'(widx(base, i) * 4);
    return a;
  endfunction

  task automatic offer_cmd(input bit wr, input logic [63:0] base, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = base;
    cmd_len   = LW'(len);
    #1;
    check_eq("cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_done_tail();
    #1;
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_in_done", busy, 1'b0);
    check_eq("no_access_done", {mem_wen, mem_ren}, 2'b00);
    check_eq("err_quiet", err, 1'b0);
    @(negedge clk);
    #1;
    check_eq("done_cleared", done, 1'b0);
    check_eq("idle_ready", cmd_ready, 1'b1);
  endtask

  task automatic do_write(input logic [63:0] base, input int len, input int vprob,
                          input bit fixed, input logic [31:0] d0);
    int sent = 0;
    int cyc = 0;
    logic [31:0] d;
    offer_cmd(1'b1, base, len);
    while (sent < len && cyc < 40 * len + 40) begin
      wr_valid = ($urandom_range(99) < vprob);
      d = fixed ? d0 + 32'(sent) : $urandom;
      wr_data = d;
      #1;
      check_eq("wr_busy", busy, 1'b1);
      check_eq("wr_ready", wr_ready, 1'b1);
      check_eq("no_rd_valid_in_write", rd_valid, 1'b0);
      check_eq("wen_eq_handshake", {mem_wen, mem_ren}, {wr_valid, 1'b0});
      if (mem_wen) begin
        check_eq("wr_addr", mem_addr, exp_addr(base, sent));
        check_eq("wr_wdata", mem_wdata, d);
        ref_mem[widx(base, sent)] = d;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    if (sent < len) check_eq("wr_timeout", 64'(sent), 64'(len));
    check_done_tail();
  endtask

  // mode 0: rd_ready held high, 1: pattern 1,0,0 repeating, 2: random
  task automatic do_read(input logic [63:0] base, input int len, input int mode);
    int issued = 0;
    int popped = 0;
    int k = 1;
    int first_k = -1;
    int last_k = -1;
    bit pop;
    offer_cmd(1'b0, base, len);
    while (popped < len && k < 40 * len + 40) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((k - 1) % 3 == 0);
        default: rd_ready = $urandom_range(1);
      endcase
      #1;
      check_eq("no_wr_ready_in_read", wr_ready, 1'b0);
      check_eq("no_wen_in_read", mem_wen, 1'b0);
      pop = rd_valid && rd_ready;
      if (mem_ren) begin
        check_eq("ren_excess", 64'(issued < len), 64'(1));
        check_eq("rd_addr", mem_addr, exp_addr(base, issued));
        issued++;
        check_eq("outstanding_le2", 64'((issued - popped - int'(pop)) <= 2), 64'(1));
      end
      check_eq("rd_last", rd_last, rd_valid && (popped == len - 1));
      if (rd_valid) begin
        check_eq("rd_data", rd_data, ref_mem[widx(base, popped)]);
        if (first_k < 0) first_k = k;
      end
      if (pop) begin
        popped++;
        last_k = k;
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    if (popped < len) check_eq("rd_timeout", 64'(popped), 64'(len));
    if (mode == 0 && len > 0) begin
      // Acceptance edge ends cycle 0; first word two cycles later, then one per cycle.
      check_eq("rd_first_latency", 64'(first_k), 64'(3));
      check_eq("rd_throughput", 64'(last_k), 64'(len + 2));
    end
    check_eq("rd_issued", 64'(issued), 64'(len));
    check_done_tail();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {cmd_ready, wr_ready, rd_valid, rd_last, busy, done, err, mem_wen, mem_ren},
             9'b1_0000_0000);
    check_eq({tag, "_addr"}, mem_addr, 64'd0);
    check_eq({tag, "_data"}, {rd_data, mem_wdata}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int popped;
    int cyc;
    logic [63:0] b;
    int ln;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    arst_n = 1'b1;

    do_write(64'h40, 4, 100, 1'b1, 32'hA0);
    do_read(64'h40, 4, 0);
    do_read(64'h40, 4, 1);

`ifdef SRAM_DMA_RANGE_CHECK_EN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 64'h3F8; cmd_len = 9'd4; wr_valid = 1'b1;
    #1;
    check_eq("rej_no_wen", mem_wen, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check_eq("rej_err", err, 1'b1);
    check_eq("rej_ready", cmd_ready, 1'b1);
    check_eq("rej_idle", {busy, done, mem_wen}, 3'b000);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check_eq("rej_err_pulse", err, 1'b0);
`else
    do_write(64'h3F8, 4, 100, 1'b1, 32'h55);
    do_read(64'h3F8, 4, 2);
`endif

    do_write(64'h100, 0, 100, 1'b0, 32'h0);
    do_read(64'h80, 0, 0);

    // Reset while the second word of a len-8 read is presented.
    offer_cmd(1'b0, 64'h40, 8);
    popped = 0;
    cyc = 0;
    rd_ready = 1'b1;
    while (!(rd_valid && popped == 1) && cyc < 50) begin
      #1;
      if (rd_valid && popped == 1) break;
      if (rd_valid) popped++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) check_eq("rst_setup_timeout", 64'(cyc), 64'(0));
    #1;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    rd_ready = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("no_done_after_reset", {done, busy}, 2'b00);
      @(negedge clk);
    end
    do_read(64'h40, 2, 0);

    for (int it = 0; it < 24; it++) begin
      b = {$urandom, $urandom};
      b[9:2] = 8'($urandom_range(243));
      ln = $urandom_range(12);
      do_write(b, ln, 60, 1'b0, 32'h0);
      do_read(b, ln, 2);
      b[9:2] = 8'($urandom_range(243));
      do_read(b, $urandom_range(12), it % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ext_dma.md
Name: sram_ext_dma

Overview:
- Burst engine that drives the external (ext) port of the data/instruction SRAM wrapper.
- Testbench or host loads programs and reads back results while the core owns the primary port.
- Accepts one command at a time: a word-burst write from an input stream, or a word-burst read to an output stream.
- Handles the SRAM's one-cycle read latency and downstream backpressure with a 2-entry buffer.

Parameters:
- DATA_W, 32: word width. Matches SRAM wrapper DATA_W.
- ADDR_W, 8: word-index bits of the memory (depth 2**ADDR_W words).
- BYTE_OFF, 2: log2 bytes per word. 2 for 32-bit wrapper, 3 for 64-bit wrapper.
- LEN_W, 9: burst length counter width.

Ports:
- clk  in  1  system clock
- arst_n  in  1  asynchronous reset, active low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine accepts command (IDLE only)
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_base  in  64  byte base address
- cmd_len  in  LEN_W  number of words
- wr_valid  in  1  write stream word valid
- wr_ready  out  1  write stream word accepted
- wr_data  in  DATA_W  write stream word
- rd_valid  out  1  read stream word valid
- rd_ready  in  1  downstream accepts read word
- rd_data  out  DATA_W  read stream word
- rd_last  out  1  qualifies final read word
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse on rejected command (see Optional Feature)
- mem_addr_ext  out  64  to SRAM addr_ext
- mem_wen_ext  out  1  to SRAM wen_ext
- mem_ren_ext  out  1  to SRAM ren_ext
- mem_wdata_ext  out  DATA_W  to SRAM wdata_ext
- mem_rdata_ext  in  DATA_W  from SRAM rdata_ext

Behaviour:
- Reset values (arst_n=0, asynchronous):
  - all outputs 0, except cmd_ready=1.
  - state IDLE, read buffer and in-flight flag cleared, counters 0.
- Reset mid-burst aborts immediately. No done. Partial writes already performed remain in memory.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_len!=0, latch the command: address = {cmd_base[63:BYTE_OFF], BYTE_OFF'b0}, remaining = cmd_len. Go to WRITE or READ; busy=1 from the next cycle.
  - cmd_len=0: go to DONE directly; no memory access.
- Address increment: +2**BYTE_OFF per word. Field [ADDR_W+BYTE_OFF-1:BYTE_OFF] wraps modulo 2**ADDR_W; bits above it are held constant.
- WRITE:
  - wr_ready=1.
  - On wr_valid&wr_ready, in the same cycle: mem_wen_ext=1, mem_wdata_ext=wr_data, mem_addr_ext=current address.
  - Then increment the address and decrement remaining. After the last word, go to DONE.
  - mem_wen_ext is 0 in every cycle without a handshake.
- READ:
  - SRAM read data appears on mem_rdata_ext the cycle after mem_ren_ext=1. It is captured into a 2-entry FIFO that cycle.
  - Issue a read (mem_ren_ext=1, address presented) only while words left to issue > 0 and (FIFO occupancy + in-flight) < 2.
  - The FIFO head drives rd_data/rd_valid. rd_last=1 when the head is the final word of the burst.
  - Simultaneous capture and pop in one cycle: occupancy unchanged.
  - Sustained throughput is 1 word/cycle when rd_ready stays high. First rd_valid is 2 cycles after command acceptance.
  - After the final rd_valid&rd_ready, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. The next command is accepted no earlier than the cycle after DONE.
- mem_wen_ext and mem_ren_ext are never both 1.
- rd_valid is never asserted in WRITE; wr_ready is never asserted in READ.

Optional Feature:
- Macro: SRAM_DMA_RANGE_CHECK_EN.
- Defined: in IDLE, a command with base word index + cmd_len > 2**ADDR_W is rejected.
  - err=1 for one cycle, no memory access, no done.
  - Stays IDLE; cmd_ready stays 1.
- Undefined: no check, wrap-around as specified; err tied 0.

Test Plan:
- Write burst: base 0x40, len 4, data 0xA0..0xA3, wr_valid always high → mem_wen_ext high 4 consecutive cycles at 0x40,0x44,0x48,0x4C; done 1 cycle after the last write; busy low after.
- Read burst, rd_ready=1: base 0x40, len 4 after the above → rd_data 0xA0..0xA3 on 4 consecutive cycles, first 2 cycles after acceptance; rd_last only on 0xA3; done next cycle.
- Backpressure: same read, rd_ready toggling 1,0,0,1,… → no word lost or duplicated; FIFO occupancy+in-flight never exceeds 2; mem_ren_ext stalls while full.
- Wrap (macro off), ADDR_W=8: write base 0x3F8, len 4 → addresses 0x3F8,0x3FC,0x000,0x004; readback matches. With macro on, same command → err pulse, no mem_wen_ext, cmd_ready stays 1.
- cmd_len=0 → done pulse 1 cycle after acceptance; no mem_wen_ext/mem_ren_ext.
- arst_n low during the 2nd word of a len-8 read → all outputs reset immediately, no done; a subsequent len-2 read completes normally.
